mem_fill_ctrl: RTL and testbench

MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

---
 rtl/mem_fill_pkg.sv | 7 +
 rtl/mem_fill_ctrl_mem_array.sv | 20 ++
 rtl/mem_fill_ctrl.sv | 67 ++++++
 tb/tb_mem_fill_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared state encoding and default geometry for the fill controller and min-finder bench
package mem_fill_pkg;
   localparam int DEPTH_DEF  = 1024;
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;
endpackage

// File: rtl/mem_fill_ctrl_mem_array.sv
// mem_array: DEPTH x DATA_W storage, synchronous write, asynchronous read; never cleared
module mem_array
   import mem_fill_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: fills a word memory from a stream, launches an external min-finder over it
// and captures the minimum it reports.
module mem_fill_ctrl
   import mem_fill_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] data,
   output logic              start,
   input  logic              min_ready,
   input  logic [DATA_W-1:0] min_out,
   output logic [DATA_W-1:0] result,
   output logic              done,
   output logic              busy
);
   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic              we;
   assign we = (state == FILL) && in_valid;
   mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk     (clk),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (data)
   );
   // start and done follow min_ready in the same cycle so the handshake costs no extra latency
   assign in_ready = state == FILL;
   assign busy     = state != IDLE;
   assign start    = (state == LAUNCH) && min_ready;
   assign done     = (state == WAIT_DONE) && min_ready;
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_addr <= '0;
         result  <= '0;
      end else begin
         case (state)
            IDLE: if (load) begin
               state   <= FILL;
               wr_addr <= '0;
            end
            FILL: if (in_valid) begin
               wr_addr <= wr_addr + ADDR_W'(1);
               if (wr_addr == ADDR_W'(DEPTH - 1)) state <= LAUNCH;
            end
            LAUNCH:    if (min_ready) state <= WAIT_ACK;
            WAIT_ACK:  if (!min_ready) state <= WAIT_DONE;
            WAIT_DONE: if (min_ready) begin
               result <= min_out;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb_mem_fill_ctrl: directed sessions against a behavioural min-finder; a scoreboard queue of
// expected minima is drained by a monitor on every done pulse.
module tb_mem_fill_ctrl;
   import mem_fill_pkg::*;
   logic       clk = 0, reset = 1, load = 0, in_valid = 0, hold = 0;
   logic [7:0] in_data = 0, data, min_out = 0, result, mf_min = 8'hFF, nxt_min, chk_exp = 0;
   logic [9:0] rd_addr, tb_rd = 0, mf_addr = 0;
   logic       in_ready, start, done, busy, min_ready, mf_busy = 0, chk_pending = 0;
   int         n_cmp = 0, n_err = 0, start_cnt = 0, wr_cnt = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   mem_fill_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rd_addr   (rd_addr),
      .data      (data),
      .start     (start),
      .min_ready (min_ready),
      .min_out   (min_out),
      .result    (result),
      .done      (done),
      .busy      (busy)
   );

   // behavioural min-finder: one address per cycle, samples data in the cycle it drives rd_addr
   assign min_ready = !mf_busy && !hold;
   assign rd_addr   = mf_busy ? mf_addr : tb_rd;
   assign nxt_min   = data < mf_min ? data : mf_min;
   always @(posedge clk) begin
      if (start && !mf_busy) begin
         mf_busy <= 1;
         mf_addr <= 0;
         mf_min  <= 8'hFF;
      end else if (mf_busy) begin
         mf_min  <= nxt_min;
         mf_addr <= mf_addr + 10'd1;
         if (mf_addr == 10'd1023) begin
            mf_busy <= 0;
            min_out <= nxt_min;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge clk) begin
      if (in_valid && in_ready) wr_cnt++;
      if (start) start_cnt++;
      if (done) begin
         check("done_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            chk_exp = exp_q.pop_front();
            chk_pending = 1;
            check("start_pulses", start_cnt, 1);
         end
         start_cnt = 0;
      end
   end

   always @(negedge clk)
      if (chk_pending) begin
         check("result", result, chk_exp);
         check("busy_after_done", busy, 0);
         chk_pending = 0;
      end

   function automatic logic [7:0] pat(input int mode, input int a);
      if (mode == 0) return 8'((a % 200) + 20);
      if (mode == 1) return a == 1023 ? 8'h03 : 8'hFF;
      if (mode == 2) return 8'(255 - (a % 250));
      if (mode == 3) return 8'h77;
      if (mode == 4) return 8'h40;
      if (mode == 5) return 8'h30;
      return 8'h10;
   endfunction

   task automatic send(input logic [7:0] v);
      int n = 0;
      in_data  = v;
      in_valid = 1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic do_load;
      load = 1;
      @(negedge clk);
      load = 0;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("session_end", busy, 0);
   endtask

   task automatic session(input int mode, input logic [7:0] exp, input bit gap, input bit hl, input bit ld);
      int n = 0;
      exp_q.push_back(exp);
      wr_cnt = 0;
      do_load;
      for (int a = 0; a < 1024; a++) begin
         if (gap && a == 500) begin
            in_data = 8'h00;
            repeat (5) begin
               @(negedge clk);
               check("gap_in_ready", in_ready, 1);
            end
         end
         if (hl && a == 1023) hold = 1;
         send(pat(mode, a));
      end
      check("in_ready_after_fill", in_ready, 0);
      if (hl) begin
         repeat (10) begin
            check("hold_start", start, 0);
            check("hold_busy", busy, 1);
            @(negedge clk);
         end
         hold = 0;
      end
      if (ld) begin
         repeat (5) @(negedge clk);
         load = 1;
         while (!done && n < 3000) begin
            @(negedge clk);
            n++;
         end
         check("done_seen", done, 1);
         @(negedge clk);
         load = 0;
      end
      wait_idle;
      repeat (2) @(negedge clk);
      check("write_count", wr_cnt, 1024);
      if (ld) repeat (3) begin
         check("busy_after_ignored_load", busy, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_start", start, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      reset = 0;
      @(negedge clk);
      session(0, 8'd20, 0, 0, 0);
      session(1, 8'h03, 0, 0, 0);
      session(2, 8'd6, 1, 0, 0);
      in_data  = 8'h00;
      in_valid = 1;
      repeat (3) @(negedge clk);
      in_valid = 0;
      for (int a = 0; a < 1024; a++) begin
         tb_rd = 10'(a);
         #1;
         check("image", data, pat(2, a));
      end
      @(negedge clk);
      session(3, 8'h77, 0, 1, 0);
      do_load;
      for (int a = 0; a < 300; a++) send(8'h01);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_result", result, 0);
      tb_rd = 10'd5;
      #1;
      check("mem_persists", data, 8'h01);
      tb_rd = 10'd300;
      #1;
      check("mem_unwritten_after_abort", data, 8'h77);
      repeat (3) @(negedge clk);
      session(4, 8'h40, 0, 0, 0);
      session(5, 8'h30, 0, 0, 1);
      session(6, 8'h10, 0, 0, 0);
      check("pending_sessions", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
